// File: rtl/mem_arbiter_pkg.sv
// Shared configuration for the memory arbiter: owner encoding, starvation
// default, write-enable encoding and the memory map constants.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam int STARVE_LIMIT_DEF = 4;

  // One-hot write size; all-zero is a read.
  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_BYTE = 3'b100;

  localparam logic [31:0] ROM_BASE = 32'h0000_0000;
  localparam logic [31:0] ROM_SIZE = 32'h0000_4000;
  localparam logic [31:0] RAM_BASE = 32'h1000_0000;
  localparam logic [31:0] RAM_SIZE = 32'h0000_1000;

  // Counter width able to hold 0..limit (at least one bit).
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive contested cycles the data port has won.
module arb_starve_counter
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int W = cnt_width(LIMIT);
  localparam logic [W-1:0] LIM_W = LIMIT[W-1:0];

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_limit = (cnt_q == LIM_W);

  // Clear wins over increment; the count sticks once it reaches the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_limit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory with a
// fixed one-cycle read latency; data wins contention until fetch starves.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,

  input  logic        d_req,
  input  logic [2:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,

  output logic        m_en,
  output logic [2:0]  m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  owner_e owner_q;
  owner_e owner_d;
  logic   contested;
  logic   fetch_win;
  logic   at_limit;

  assign contested = i_req & d_req;
  assign fetch_win = i_req & (~d_req | at_limit);

  // Grants are gated by rst_n so nothing reaches memory while in reset.
  assign i_ready = rst_n & fetch_win;
  assign d_ready = rst_n & d_req & ~fetch_win;

  always_comb begin
    m_en    = i_ready | d_ready;
    m_we    = WE_NONE;
    m_addr  = '0;
    m_wdata = '0;
    owner_d = OWN_NONE;
    if (d_ready) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      owner_d = OWN_DATA;
    end else if (i_ready) begin
      m_addr  = i_addr;
      owner_d = OWN_FETCH;
    end
  end

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (d_ready & contested),
    .clr      (i_ready),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Response routing: memory data belongs to whoever was granted last cycle.
  assign i_rvalid = (owner_q == OWN_FETCH);
  assign d_rvalid = (owner_q == OWN_DATA);
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, queue-based response model,
// vector table, directed corner sequences and randomized traffic.
module tb_mem_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [2:0]  d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_ready, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic [2:0]  m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic        i_ready0, i_rvalid0, d_ready0, d_rvalid0, m_en0;
  logic [31:0] i_rdata0, d_rdata0, m_addr0, m_wdata0, m_rdata0;
  logic [2:0]  m_we0;

  assign m_rdata0 = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  mem_arbiter #(.STARVE_LIMIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready0), .i_rvalid(i_rvalid0), .i_rdata(i_rdata0),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
    .m_en(m_en0), .m_we(m_we0), .m_addr(m_addr0), .m_wdata(m_wdata0), .m_rdata(m_rdata0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural single-port memory, one-cycle read latency.
  logic [31:0] mem [0:1023];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [2:0] we,
                                        input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    if (we[0])      r = wd;
    else if (we[1]) begin
      if (a[1]) r[31:16] = wd[15:0];
      else      r[15:0]  = wd[15:0];
    end else if (we[2]) r[a*8 +: 8] = wd[7:0];
    return r;
  endfunction

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'hC0DE_0000 | (k << 2);
  end

  always @(posedge clk) begin
    if (m_en) begin
      m_rdata <= mem[m_addr[11:2]];
      if (m_we != 3'b000) mem[m_addr[11:2]] = merge(mem[m_addr[11:2]], m_we, m_addr[1:0], m_wdata);
    end
  end

  // Reference model: expected grant from the arbitration rules, and a queue of
  // outstanding responses that must each come back exactly one cycle later.
  typedef struct {
    int          port;   // 0 none, 1 fetch, 2 data
    bit          rd;
    logic [31:0] data;
  } rsp_t;

  rsp_t sbq[$];
  rsp_t r;
  int   mcnt = 0;
  int   eg;
  int   eg0;
  int   p0 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_i_ready", i_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_m_en", m_en, 0);
      chk("rst_i_rvalid", i_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst0_grant", {i_ready0, d_ready0, i_rvalid0, d_rvalid0}, 0);
      sbq.delete();
      mcnt = 0;
      p0 = 0;
    end else begin
      if (i_req && d_req) eg = (mcnt >= LIM) ? 1 : 2;
      else if (i_req)     eg = 1;
      else if (d_req)     eg = 2;
      else                eg = 0;
      chk("i_ready", i_ready, eg == 1);
      chk("d_ready", d_ready, eg == 2);
      chk("m_en", m_en, eg != 0);
      chk("mutex", i_ready & d_ready, 0);
      if (eg == 1) begin
        chk("m_addr_i", m_addr, i_addr);
        chk("m_we_i", m_we, 0);
      end else if (eg == 2) begin
        chk("m_addr_d", m_addr, d_addr);
        chk("m_we_d", m_we, d_we);
        chk("m_wdata_d", m_wdata, d_wdata);
      end

      if (sbq.size() > 0) r = sbq.pop_front();
      else begin r.port = 0; r.rd = 0; r.data = 0; end
      chk("i_rvalid", i_rvalid, r.port == 1);
      chk("d_rvalid", d_rvalid, r.port == 2);
      chk("i_rdata", i_rdata, (r.port == 1) ? r.data : 32'h0);
      if (r.port != 2)  chk("d_rdata_zero", d_rdata, 0);
      else if (r.rd)    chk("d_rdata", d_rdata, r.data);

      if (eg == 1) mcnt = 0;
      else if (eg == 2 && i_req) mcnt = (mcnt + 1 > LIM) ? LIM : mcnt + 1;
      if (eg == 1) sbq.push_back('{1, 1'b1, mem[i_addr[11:2]]});
      if (eg == 2) sbq.push_back('{2, d_we == 3'b000, mem[d_addr[11:2]]});

      // Zero-limit instance: fetch always wins, its memory reads back zero.
      eg0 = i_req ? 1 : (d_req ? 2 : 0);
      chk("l0_i_ready", i_ready0, eg0 == 1);
      chk("l0_d_ready", d_ready0, eg0 == 2);
      chk("l0_m_en", m_en0, eg0 != 0);
      if (eg0 == 1) chk("l0_m_addr", m_addr0, i_addr);
      if (eg0 == 2) chk("l0_m_cmd", {m_addr0 ^ m_wdata0, 29'h0, m_we0},
                        {d_addr ^ d_wdata, 29'h0, d_we});
      chk("l0_rvalid", {i_rvalid0, d_rvalid0}, {p0 == 1, p0 == 2});
      chk("l0_rdata", i_rdata0 | d_rdata0, 0);
      p0 = eg0;
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [2:0] dw, input logic [31:0] da, input logic [31:0] dd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(0, 32'h1000_0000, 0, 3'b000, 32'h1000_0000, 0);
    rst_n = 0;
    next_cycle();
    next_cycle();
    rst_n = 1;
  endtask

  typedef struct {
    logic       ir;
    logic       dr;
    logic [1:0] exp;   // {i_ready, d_ready}
  } vec_t;

  vec_t vt[15];
  int   wait_c, max_wait;
  logic ia, da;
  logic [2:0] wsel;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 32'h1000_0000, 0, 3'b000, 32'h1000_0000, 0);
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Grant sequence from a fresh count of zero.
    vt[0]  = '{1, 1, 2'b01}; vt[1]  = '{1, 1, 2'b01}; vt[2]  = '{1, 1, 2'b01};
    vt[3]  = '{1, 1, 2'b01}; vt[4]  = '{1, 1, 2'b10}; vt[5]  = '{1, 1, 2'b01};
    vt[6]  = '{0, 1, 2'b01}; vt[7]  = '{1, 0, 2'b10}; vt[8]  = '{0, 0, 2'b00};
    vt[9]  = '{1, 1, 2'b01}; vt[10] = '{0, 1, 2'b01}; vt[11] = '{1, 1, 2'b01};
    vt[12] = '{1, 1, 2'b01}; vt[13] = '{1, 1, 2'b01}; vt[14] = '{1, 1, 2'b10};
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(vt[k].ir, 32'h1000_0100, vt[k].dr, 3'b000, 32'h1000_0200, 0);
      @(negedge clk);
      chk($sformatf("tbl_grant%0d", k), {i_ready, d_ready}, vt[k].exp);
      next_cycle();
    end

    // Fetch-only burst of three at the same address.
    do_reset();
    drive(1, 32'h1000_0040, 0, 3'b000, 32'h1000_0000, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("fetch_rdy%0d", c), i_ready, c <= 3);
      chk($sformatf("fetch_rv%0d", c), i_rvalid, c >= 2 && c <= 4);
      if (c >= 2 && c <= 4) chk($sformatf("fetch_data%0d", c), i_rdata, 32'hC0DE_0040);
      next_cycle();
      if (c == 3) i_req = 0;
    end

    // Word write then read-back.
    drive(0, 32'h1000_0000, 1, 3'b001, 32'h1000_0010, 32'hDEAD_BEEF);
    @(negedge clk); chk("wr_rdy", d_ready, 1);
    next_cycle(); d_we = 3'b000;
    @(negedge clk); chk("rd_rdy", {d_ready, d_rvalid}, 2'b11);
    next_cycle(); d_req = 0;
    @(negedge clk); chk("rd_rv", d_rvalid, 1); chk("rd_data", d_rdata, 32'hDEAD_BEEF);
    next_cycle();
    @(negedge clk); chk("rd_rv_end", d_rvalid, 0);
    next_cycle();

    // Continuous contention: D,D,D,D,I repeating; zero-limit always fetch.
    do_reset();
    drive(1, 32'h1000_0080, 1, 3'b000, 32'h1000_0020, 0);
    wait_c = 0; max_wait = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("pat%0d", c), {i_ready, d_ready}, (c % 5 == 4) ? 2'b10 : 2'b01);
      chk($sformatf("l0_pat%0d", c), {i_ready0, d_ready0}, 2'b10);
      if (i_ready) wait_c = 0;
      else begin wait_c++; if (wait_c > max_wait) max_wait = wait_c; end
      next_cycle();
    end
    chk("fetch_max_wait", max_wait, 4);
    i_req = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("l0_dataonly%0d", c), {i_ready0, d_ready0}, 2'b01);
      next_cycle();
    end

    // Reset right after a data accept drops the response and clears the count.
    do_reset();
    drive(1, 32'h1000_0080, 1, 3'b000, 32'h1000_0020, 0);
    repeat (2) begin @(negedge clk); next_cycle(); end
    i_req = 0;
    @(negedge clk); chk("rst_acc", d_ready, 1);
    next_cycle();
    rst_n = 0; d_req = 0;
    @(negedge clk); chk("rst_drop0", d_rvalid, 0);
    next_cycle();
    @(negedge clk); chk("rst_drop1", d_rvalid, 0);
    next_cycle();
    rst_n = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); chk($sformatf("post_rst_rv%0d", c), {i_rvalid, d_rvalid}, 0);
      next_cycle();
    end
    drive(1, 32'h1000_0080, 1, 3'b000, 32'h1000_0020, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_pat%0d", c), {i_ready, d_ready}, (c == 4) ? 2'b10 : 2'b01);
      next_cycle();
    end

    // Randomized traffic; the model checks every cycle.
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      ia = i_ready; da = d_ready;
      next_cycle();
      rst_n = ($urandom_range(0, 499) != 0);
      if (!i_req || ia) begin
        i_req  = ($urandom_range(0, 99) < 60);
        i_addr = 32'h1000_0000 | ($urandom_range(0, 255) << 2);
      end
      if (!d_req || da) begin
        d_req   = ($urandom_range(0, 99) < 55);
        wsel    = 3'($urandom_range(0, 3));
        d_we    = (wsel == 0) ? 3'b000 : (wsel == 1) ? 3'b001 : (wsel == 2) ? 3'b010 : 3'b100;
        d_addr  = 32'h1000_0000 | ($urandom_range(0, 63) << 2);
        if (d_we == 3'b010) d_addr = d_addr | ($urandom_range(0, 1) << 1);
        if (d_we == 3'b100) d_addr = d_addr | $urandom_range(0, 3);
        d_wdata = $urandom;
      end
    end
    rst_n = 1;
    drive(0, 32'h1000_0000, 0, 3'b000, 32'h1000_0000, 0);
    repeat (3) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
